accel_stream_wrapper: RTL and testbench

- Parametrised successor to the BRAM-based accelerator wrapper.
- Host-side load/run/drain sequencer around the accelerator core: packs HOST_W-bit host writes into wide x and w operand registers, launches the core, captures the wide result, and streams it out as OUT_W-bit words with valid/ready.
- Adds weight-reuse mode, start qualification and back-pressured readout.
- Sits between the host bus and the accelerator core instance.

---
 rtl/accel_stream_wrapper_pkg.sv | 27 ++
 rtl/accel_stream_wrapper_operand_packer.sv | 40 ++++
 rtl/accel_stream_wrapper.sv | 146 ++++++++++++++
 tb/tb_accel_stream_wrapper.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_stream_wrapper_pkg.sv
// Shared types and default-derived sizes for the accelerator stream wrapper.
// Sequencer state encoding plus counter-width helpers used by the top and the packers.
package accel_stream_wrapper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Sizes at the default parameterisation (16b x 5 x 10 operands, 32b results, 32b host, 64b readout)
  localparam int XW = 16 * 5 * 10;
  localparam int RW = 32 * 5 * 10;
  localparam int NX = XW / 32;
  localparam int NR = RW / 64;

  // Counter that must hold 0..n inclusive
  function automatic int cnt_bits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Index that must hold 0..n-1
  function automatic int idx_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/accel_stream_wrapper_operand_packer.sv
// Packs NW host words of HOST_W bits into one wide operand bank, word 0 at the LSB.
// The word counter doubles as the fill level; clr empties the bank without erasing its contents.
module accel_stream_wrapper_operand_packer
  import accel_stream_wrapper_pkg::*;
#(
  parameter int HOST_W = 32,
  parameter int NW     = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [HOST_W-1:0]    wr_data,
  input  logic                 clr,
  output logic [HOST_W*NW-1:0] data,
  output logic                 full,
  output logic                 last_slot
);

  localparam int CNT_W = cnt_bits(NW);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      data <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (wr_en && !full) begin
      for (int i = 0; i < NW; i++) begin
        if (cnt == CNT_W'(i)) data[i*HOST_W +: HOST_W] <= wr_data;
      end
      cnt <= cnt + 1'b1;
    end
  end

  assign full      = (cnt == CNT_W'(NW));
  assign last_slot = (cnt == CNT_W'(NW - 1));

endmodule

// File: rtl/accel_stream_wrapper.sv
// Load/run/drain sequencer between the host bus and the accelerator core.
// Optional 32-bit RUN cycle counter output run_cycles when ACC_CYCLE_CNT_EN is defined.
module accel_stream_wrapper
  import accel_stream_wrapper_pkg::*;
#(
  parameter int INPUT_BITWIDTH = 16,
  parameter int BITWIDTH       = 32,
  parameter int SIZE           = 5,
  parameter int NUM_UNIT       = 10,
  parameter int HOST_W         = 32,
  parameter int OUT_W          = 64
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     wr_valid,
  output logic                                     wr_ready,
  input  logic                                     wr_sel,
  input  logic [HOST_W-1:0]                        wr_data,
  input  logic                                     keep_w,
  input  logic [INPUT_BITWIDTH-1:0]                mu_in,
  input  logic [INPUT_BITWIDTH-1:0]                bias_in,
  input  logic                                     start,
  output logic                                     start_err,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     core_start,
  input  logic                                     core_done,
  output logic [INPUT_BITWIDTH*SIZE*NUM_UNIT-1:0]  core_x,
  output logic [INPUT_BITWIDTH*SIZE*NUM_UNIT-1:0]  core_w,
  output logic [INPUT_BITWIDTH-1:0]                core_mu,
  output logic [INPUT_BITWIDTH-1:0]                core_bias,
  input  logic [BITWIDTH*SIZE*NUM_UNIT-1:0]        core_r,
  output logic                                     rd_valid,
  input  logic                                     rd_ready,
  output logic [OUT_W-1:0]                         rd_data,
  output logic                                     rd_last
`ifdef ACC_CYCLE_CNT_EN
  ,
  output logic [31:0]                              run_cycles
`endif
);

  localparam int BANK_W = INPUT_BITWIDTH * SIZE * NUM_UNIT;
  localparam int RES_W  = BITWIDTH * SIZE * NUM_UNIT;
  localparam int N_WR   = BANK_W / HOST_W;
  localparam int N_RD   = RES_W / OUT_W;
  localparam int IDX_W  = idx_bits(N_RD);

  state_t           state;
  logic             keep_w_q;
  logic [RES_W-1:0] result;
  logic [IDX_W-1:0] idx;

  logic x_full, w_full, x_last, w_last;
  logic x_wr, w_wr, x_full_nx, w_full_nx;
  logic start_ok, leave_run, rd_fire, drain_end;

  assign wr_ready  = (state == ST_IDLE) && !(wr_sel ? w_full : x_full);
  assign x_wr      = wr_valid && wr_ready && !wr_sel;
  assign w_wr      = wr_valid && wr_ready && wr_sel;

  // A write that fills the last slot counts toward a start in the same cycle
  assign x_full_nx = x_full || (x_wr && x_last);
  assign w_full_nx = w_full || (w_wr && w_last);
  assign start_ok  = (state == ST_IDLE) && start && x_full_nx && w_full_nx;
  assign leave_run = (state == ST_RUN) && core_done && !core_start;

  assign rd_valid  = (state == ST_DRAIN);
  assign rd_last   = rd_valid && (idx == IDX_W'(N_RD - 1));
  assign rd_fire   = rd_valid && rd_ready;
  assign drain_end = rd_fire && rd_last;
  assign done      = drain_end;
  assign busy      = (state != ST_IDLE);

  accel_stream_wrapper_operand_packer #(.HOST_W(HOST_W), .NW(N_WR)) u_x_bank (
    .clk(clk), .rst(rst), .wr_en(x_wr), .wr_data(wr_data), .clr(drain_end),
    .data(core_x), .full(x_full), .last_slot(x_last)
  );

  accel_stream_wrapper_operand_packer #(.HOST_W(HOST_W), .NW(N_WR)) u_w_bank (
    .clk(clk), .rst(rst), .wr_en(w_wr), .wr_data(wr_data), .clr(drain_end && !keep_w_q),
    .data(core_w), .full(w_full), .last_slot(w_last)
  );

  always_comb begin
    rd_data = '0;
    if (rd_valid) begin
      for (int i = 0; i < N_RD; i++) begin
        if (idx == IDX_W'(i)) rd_data = result[i*OUT_W +: OUT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      keep_w_q   <= 1'b0;
      core_mu    <= '0;
      core_bias  <= '0;
      result     <= '0;
      idx        <= '0;
      core_start <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      core_start <= 1'b0;
      start_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state      <= ST_RUN;
            core_start <= 1'b1;
            keep_w_q   <= keep_w;
            core_mu    <= mu_in;
            core_bias  <= bias_in;
          end else if (start) begin
            start_err <= 1'b1;
          end
        end
        ST_RUN: begin
          if (leave_run) begin
            result <= core_r;
            idx    <= '0;
            state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (rd_fire) begin
            if (rd_last) state <= ST_IDLE;
            else         idx   <= idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ACC_CYCLE_CNT_EN
  // Counts RUN cycles that precede the accepted completion; saturates rather than wraps
  always_ff @(posedge clk) begin
    if (rst)                                       run_cycles <= '0;
    else if (start_ok)                             run_cycles <= '0;
    else if (state == ST_RUN && !leave_run && run_cycles != '1) run_cycles <= run_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_accel_stream_wrapper.sv
// Randomised self-checking bench for accel_stream_wrapper at default parameters.
// Reference model: bank contents as plain vectors, fill counts and the captured result.
module tb_accel_stream_wrapper;

  logic          clk = 1'b0;
  logic          rst, wr_valid, wr_sel, keep_w, start, core_done, rd_ready;
  logic [31:0]   wr_data;
  logic [15:0]   mu_in, bias_in;
  logic          wr_ready, start_err, busy, done, core_start, rd_valid, rd_last;
  logic [799:0]  core_x, core_w;
  logic [15:0]   core_mu, core_bias;
  logic [1599:0] core_r;
  logic [63:0]   rd_data;
`ifdef ACC_CYCLE_CNT_EN
  logic [31:0]   run_cycles;
`endif

  accel_stream_wrapper dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
    .wr_data(wr_data), .keep_w(keep_w), .mu_in(mu_in), .bias_in(bias_in), .start(start),
    .start_err(start_err), .busy(busy), .done(done), .core_start(core_start),
    .core_done(core_done), .core_x(core_x), .core_w(core_w), .core_mu(core_mu),
    .core_bias(core_bias), .core_r(core_r), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last)
`ifdef ACC_CYCLE_CNT_EN
    , .run_cycles(run_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [799:0]  xv = '0, wv = '0;
  logic [1599:0] rv = '0;
  int            xcnt = 0, wcnt = 0;
  logic          keep_m = 1'b0;
  logic [15:0]   mu_m = '0, bias_m = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [31:0] d);
    logic exp_rdy;
    wr_valid = 1'b1; wr_sel = sel; wr_data = d;
    #1;
    exp_rdy = sel ? (wcnt < 25) : (xcnt < 25);
    chk(sel ? "wr_ready_w" : "wr_ready_x", {63'd0, wr_ready}, {63'd0, exp_rdy});
    step();
    wr_valid = 1'b0;
    if (exp_rdy) begin
      if (sel) begin wv[wcnt*32 +: 32] = d; wcnt++; end
      else     begin xv[xcnt*32 +: 32] = d; xcnt++; end
    end
  endtask

  task automatic do_start(input logic keep);
    logic acc;
    start = 1'b1; keep_w = keep;
    mu_in = 16'($urandom); bias_in = 16'($urandom);
    acc = (xcnt == 25) && (wcnt == 25);
    step();
    start = 1'b0;
    if (acc) begin
      keep_m = keep; mu_m = mu_in; bias_m = bias_in;
      chk("start_core_start", {63'd0, core_start}, 64'd1);
      chk("start_busy", {63'd0, busy}, 64'd1);
      chk("start_no_err", {63'd0, start_err}, 64'd0);
      chk("core_mu", {48'd0, core_mu}, {48'd0, mu_m});
      chk("core_bias", {48'd0, core_bias}, {48'd0, bias_m});
    end else begin
      chk("reject_err", {63'd0, start_err}, 64'd1);
      chk("reject_busy", {63'd0, busy}, 64'd0);
      chk("reject_core_start", {63'd0, core_start}, 64'd0);
      step();
      chk("reject_err_pulse", {63'd0, start_err}, 64'd0);
    end
  endtask

  // Core replies lat cycles after core_start; an early pulse in the core_start cycle must be ignored
  task automatic run_core(input int lat, input logic early);
    for (int k = 0; k < lat; k++) begin
      core_done = early && (k == 0);
      if (k > 0) chk("core_start_once", {63'd0, core_start}, 64'd0);
      step();
      core_done = 1'b0;
      chk("run_busy", {63'd0, busy}, 64'd1);
      chk("run_no_rd", {63'd0, rd_valid}, 64'd0);
    end
    for (int i = 0; i < 50; i++) rv[i*32 +: 32] = $urandom;
    core_r = rv; core_done = 1'b1;
    step();
    core_done = 1'b0; core_r = ~rv;
`ifdef ACC_CYCLE_CNT_EN
    chk("run_cycles", {32'd0, run_cycles}, 64'(lat));
`endif
  endtask

  // mode 0: always ready, 1: ready toggles each cycle, 2: random ready
  task automatic drain(input int mode);
    int idx = 0;
    int cyc = 0;
    while (idx < 25 && cyc < 300) begin
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom);
      #1;
      chk("rd_valid", {63'd0, rd_valid}, 64'd1);
      chk("rd_data", rd_data, rv[idx*64 +: 64]);
      chk("rd_last", {63'd0, rd_last}, {63'd0, idx == 24});
      chk("done", {63'd0, done}, {63'd0, rd_ready && idx == 24});
      chk("drain_wr_ready", {63'd0, wr_ready}, 64'd0);
      @(posedge clk);
      #1;
      if (rd_ready) idx++;
      cyc++;
    end
    if (idx < 25) chk("drain_timeout", 64'(idx), 64'd25);
    rd_ready = 1'b0;
    xcnt = 0;
    if (!keep_m) wcnt = 0;
    #1;
    chk("post_busy", {63'd0, busy}, 64'd0);
    chk("post_done", {63'd0, done}, 64'd0);
    chk("post_rd_valid", {63'd0, rd_valid}, 64'd0);
  endtask

  task automatic probe_ready(input logic sel, input logic exp);
    wr_sel = sel;
    #1;
    chk(sel ? "idle_ready_w" : "idle_ready_x", {63'd0, wr_ready}, {63'd0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_valid = 0; wr_sel = 0; wr_data = '0; keep_w = 0; mu_in = '0; bias_in = '0;
    start = 0; core_done = 0; rd_ready = 0; core_r = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_core_start", {63'd0, core_start}, 64'd0);
    chk("rst_start_err", {63'd0, start_err}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_core_x", {63'd0, core_x == '0}, 64'd1);
    chk("rst_core_w", {63'd0, core_w == '0}, 64'd1);
    chk("rst_core_mu", {48'd0, core_mu}, 64'd0);
    rst = 1'b0;
    step();

    // 24 x words: start rejected; fill x, overflow write blocked while w still accepted
    for (int i = 0; i < 24; i++) wr(1'b0, 32'(i + 1));
    do_start(1'b0);
    wr(1'b0, 32'd25);
    wr(1'b0, 32'hdead_beef);
    for (int i = 0; i < 25; i++) wr(1'b1, $urandom);
    do_start(1'b0);
    chk("core_x_lo", {32'd0, core_x[31:0]}, 64'd1);
    chk("core_x_hi", {32'd0, core_x[799:768]}, 64'h19);
    chk("core_x", {63'd0, core_x == xv}, 64'd1);
    chk("core_w", {63'd0, core_w == wv}, 64'd1);
    run_core(7, 1'b0);
    drain(1);
    probe_ready(1'b0, 1'b1);
    probe_ready(1'b1, 1'b1);

    // keep_w run; last w write and start share a cycle
    for (int i = 0; i < 25; i++) wr(1'b0, $urandom);
    for (int i = 0; i < 24; i++) wr(1'b1, $urandom);
    wr_valid = 1'b1; wr_sel = 1'b1; wr_data = $urandom; start = 1'b1; keep_w = 1'b1;
    mu_in = 16'($urandom); bias_in = 16'($urandom);
    step();
    wr_valid = 1'b0; start = 1'b0;
    wv[24*32 +: 32] = wr_data; wcnt = 25; keep_m = 1'b1;
    chk("same_cycle_start", {63'd0, core_start}, 64'd1);
    chk("same_cycle_core_w", {63'd0, core_w == wv}, 64'd1);
    chk("same_cycle_mu", {48'd0, core_mu}, {48'd0, mu_in});
    run_core(4, 1'b1);
    drain(2);
    probe_ready(1'b1, 1'b0);
    probe_ready(1'b0, 1'b1);

    // x-only reload reuses the kept w bank
    for (int i = 0; i < 25; i++) wr(1'b0, $urandom);
    do_start(1'b0);
    chk("reuse_core_w", {63'd0, core_w == wv}, 64'd1);
    chk("reuse_core_x", {63'd0, core_x == xv}, 64'd1);
    run_core(3, 1'b0);
    drain(0);

    // Without keep_w the same x-only sequence is rejected
    for (int i = 0; i < 25; i++) wr(1'b0, $urandom);
    do_start(1'b0);

    // Reset during RUN, then a stale core_done
    for (int i = 0; i < 25; i++) wr(1'b1, $urandom);
    do_start(1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    xcnt = 0; wcnt = 0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_core_start", {63'd0, core_start}, 64'd0);
    chk("midrst_core_x", {63'd0, core_x == '0}, 64'd1);
    chk("midrst_core_w", {63'd0, core_w == '0}, 64'd1);
    chk("midrst_mu", {48'd0, core_mu}, 64'd0);
`ifdef ACC_CYCLE_CNT_EN
    chk("midrst_run_cycles", {32'd0, run_cycles}, 64'd0);
`endif
    probe_ready(1'b0, 1'b1);
    probe_ready(1'b1, 1'b1);
    core_done = 1'b1; core_r = {50{32'h1234_5678}};
    step();
    core_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_done_rd_valid", {63'd0, rd_valid}, 64'd0);
      chk("late_done_busy", {63'd0, busy}, 64'd0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
